// File: rtl/sr_cmd_gen.sv
// sr_cmd_gen: cleans a raw bouncing level and turns every accepted
// transition into a stretched, mutually exclusive S/R command pair for
// the downstream pulse-triggered SR latch. Also exports the debounced
// level, single-cycle rise/fall strobes and a busy flag.
module sr_cmd_gen #(
  parameter int CNT_W     = 4,
  parameter int DEBOUNCE  = 8,
  parameter int PULSE_LEN = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic S,
  output logic R,
  output logic level,
  output logic rise,
  output logic fall,
  output logic busy
);

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE - 1);
  localparam logic [3:0]       PLEN     = 4'(PULSE_LEN);

  logic             r_s1;
  logic             r_s2;
  logic             r_level;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_stretch;
  logic             r_rise;
  logic             r_fall;
  logic             r_s;
  logic             r_r;
  logic             r_busy;

  logic             w_mismatch;
  logic             w_accept;
  logic [CNT_W-1:0] w_cntNext;
  logic [3:0]       w_stretchNext;
  logic             w_sNext;
  logic             w_rNext;

  // Next-state decode: debounce count, stretch count and S/R, where a newly
  // accepted edge always overrides any stretch still in progress.
  always_comb begin
    w_mismatch    = r_s2 ^ r_level;
    w_accept      = w_mismatch && (r_cnt == DEB_LAST);
    w_cntNext     = '0;
    w_stretchNext = '0;
    w_sNext       = 1'b0;
    w_rNext       = 1'b0;
    if (w_mismatch && !w_accept) begin
      w_cntNext = r_cnt + 1'b1;
    end
    if (w_accept) begin
      w_stretchNext = PLEN;
      w_sNext       = r_s2;
      w_rNext       = ~r_s2;
    end else if (r_stretch != 4'd0) begin
      w_stretchNext = r_stretch - 4'd1;
      w_sNext       = (w_stretchNext != 4'd0) && r_s;
      w_rNext       = (w_stretchNext != 4'd0) && r_r;
    end
  end

  // Two-flop synchronizer for the asynchronous raw input.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= din;
      r_s2 <= r_s1;
    end
  end

  // Debounced level, edge strobes, counters, S/R commands and busy flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_level   <= 1'b0;
      r_cnt     <= '0;
      r_stretch <= '0;
      r_rise    <= 1'b0;
      r_fall    <= 1'b0;
      r_s       <= 1'b0;
      r_r       <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_level <= r_s2;
      end
      r_cnt     <= w_cntNext;
      r_stretch <= w_stretchNext;
      r_rise    <= w_accept && r_s2;
      r_fall    <= w_accept && !r_s2;
      r_s       <= w_sNext;
      r_r       <= w_rNext;
      r_busy    <= (w_cntNext != '0) || (w_stretchNext != 4'd0);
    end
  end

  assign S     = r_s;
  assign R     = r_r;
  assign level = r_level;
  assign rise  = r_rise;
  assign fall  = r_fall;
  assign busy  = r_busy;

endmodule

// File: doc/sr_cmd_gen.md
Name: sr_cmd_gen

Overview:
- Upstream command stage for the pulse-triggered SR latch.
- Takes a raw, possibly bouncing asynchronous level `din` and synchronizes and debounces it.
- Converts each clean transition into a stretched, mutually exclusive S/R command pair (set on rise, reset on fall) that the latch consumes directly.
- Also exports the debounced level and single-cycle edge strobes for other logic.

Parameters:
- CNT_W, 4, width of the debounce counter; must satisfy 2^CNT_W >= DEBOUNCE.
- DEBOUNCE, 8, consecutive cycles the synchronized input must differ from the stable level before it is accepted; legal range 1..2^CNT_W.
- PULSE_LEN, 2, cycles S or R stays high per accepted edge; legal range 1..15.

Ports:
- clk, input, 1, single system clock; all state updates on its rising edge.
- reset, input, 1, synchronous, active-high reset.
- din, input, 1, raw asynchronous level to be cleaned.
- S, output, 1, set command to the latch; high PULSE_LEN cycles after an accepted rise.
- R, output, 1, reset command to the latch; high PULSE_LEN cycles after an accepted fall.
- level, output, 1, debounced stable level.
- rise, output, 1, one-cycle strobe when `level` goes 0->1.
- fall, output, 1, one-cycle strobe when `level` goes 1->0.
- busy, output, 1, high while the debounce counter is nonzero or S/R is being stretched.

Behaviour:
- Reset: applied at a clk edge while reset=1, it dominates all other activity.
  - Clears the sync flops, stable level, debounce counter and stretch counter.
  - Outputs after reset: S=0, R=0, level=0, rise=0, fall=0, busy=0.
  - Reset mid-debounce or mid-stretch aborts it; no pending edge is emitted afterwards.
- Synchronizer: two flops, s1<=din, s2<=s1. Only s2 is used downstream.
- Debounce counter:
  - At each edge, if s2 != level and cnt == DEBOUNCE-1: level<=s2, cnt<=0, and rise or fall is set for the next cycle.
  - Else if s2 != level: cnt<=cnt+1.
  - Else (s2 == level): cnt<=0.
  - A glitch must persist in s2 for DEBOUNCE consecutive edges to be accepted; any return to match restarts the count from 0.
- Latency: if din changes before edge k and holds, s2 changes at edge k+1 and level changes at edge k+1+DEBOUNCE. rise/fall go high for exactly the one cycle following that edge.
- rise and fall are registered and never both high.
- S/R stretch:
  - On the same edge that updates level, load the stretch counter with PULSE_LEN and drive S=1,R=0 for a rise, or S=0,R=1 for a fall.
  - Each later edge decrements the counter; when it reaches 0, S and R return to 0.
  - S is first high in the same cycle as rise.
- New accepted edge during a stretch (only possible when DEBOUNCE < PULSE_LEN): the new edge wins. Counter reloads, the opposite output drops in that same cycle, and S and R are never both 1.
- S=R=0 is the latch hold state; this block never produces S=R=1 under any input sequence.
- busy = (cnt != 0) or (stretch counter != 0), registered.
- DEBOUNCE=1: a change in s2 is accepted at the first mismatched edge.
- Counter never wraps, because the accept condition fires at DEBOUNCE-1.
- din X/unknown after reset is not a supported input; the bench drives 0/1 only.

Test Plan (DEBOUNCE=8, PULSE_LEN=2 unless noted):
- Reset: hold reset=1 for 3 cycles with din toggling every cycle -> S=R=level=rise=fall=busy=0 throughout and on the first cycle after release.
- Clean rise: din 0->1 before edge 0, held -> level=1 after edge 9; rise=1 only in cycle 9-10; S=1 for cycles 9-11; R=0 throughout.
- Glitch rejection: din high for 5 cycles then low -> level, rise, fall, S and R stay 0; busy pulses and returns to 0.
- Bounce then settle: din toggles 1,0,1,0 on successive cycles, then holds 1 -> exactly one rise, timed 8 edges after s2 last becomes 1; exactly one 2-cycle S pulse.
- Fall after rise: accept a rise, wait 20 cycles, drop din -> exactly one fall and a 2-cycle R pulse; S=0 during the R pulse.
- Overlap (DEBOUNCE=1, PULSE_LEN=4): din 0->1, then 1->0 two cycles later -> S high 2 cycles, then R high 4 cycles with the handover in a single cycle; S&R never 1; reset asserted during the R pulse clears R at the next edge.
